// File: rtl/seg_scan_capture.sv
// seg_scan_capture: demultiplexes a scanned 4-digit seven-segment bus back into per-digit frames
// Ports: clk, reset (async, active-high); anodes[3:0] / segments[6:0] active-low inputs;
// frame[27:0] = {slot3,slot2,slot1,slot0} active-high, frame_valid, frame_count[7:0],
// capture_strobe, active_slot[1:0], overlap_err (sticky), scan_stalled.
// Optional macro SEG_DECODE_EN adds hex_digits[15:0] / hex_ok[3:0], decoded per completed frame.
module seg_scan_capture #(
  parameter int SETTLE_CYCLES  = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  anodes,
  input  logic [6:0]  segments,
  output logic [27:0] frame,
  output logic        frame_valid,
  output logic [7:0]  frame_count,
  output logic        capture_strobe,
  output logic [1:0]  active_slot,
  output logic        overlap_err,
`ifdef SEG_DECODE_EN
  output logic [15:0] hex_digits,
  output logic [3:0]  hex_ok,
`endif
  output logic        scan_stalled
);
  localparam int SW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] TO = SW'(TIMEOUT_CYCLES);
  localparam logic [3:0] SETTLE_N = 4'(SETTLE_CYCLES);
  typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d, seen_q, seen_d;
  logic [1:0] slot_q, slot_d, slot, as_q, as_d;
  logic [27:0] shadow_q, shadow_d, frame_q, frame_d;
  logic [7:0] fc_q, fc_d;
  logic fv_q, fv_d, cs_q, cs_d, ov_q, ov_d, st_q, st_d, blank, one_hot, cap;
  logic [SW-1:0] stall_q, stall_d;
  always_comb begin
    blank = anodes == 4'hf;
    one_hot = $countones(~anodes) == 1;
    slot = !anodes[3] ? 2'd0 : !anodes[2] ? 2'd1 : !anodes[1] ? 2'd2 : 2'd3;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    slot_d = slot_q;
    ov_d = ov_q;
    cap = 1'b0;
    if (!blank && !one_hot) begin
      ov_d = 1'b1;
      state_d = IDLE;
      cnt_d = '0;
    end else if (blank) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (!(state_q == HOLD && slot == slot_q)) begin
      // a new slot (or entry from IDLE) restarts the settle count; HOLD on the same slot never recaptures
      slot_d = slot;
      cnt_d = (state_q == IDLE || slot != slot_q) ? 4'd1 : cnt_q + 4'd1;
      cap = cnt_d == SETTLE_N;
      state_d = cap ? HOLD : SETTLE;
    end
  end
  always_comb begin
    shadow_d = shadow_q;
    seen_d = seen_q;
    frame_d = frame_q;
    fv_d = 1'b0;
    fc_d = fc_q;
    cs_d = cap;
    as_d = as_q;
    stall_d = cap ? '0 : (stall_q == TO ? stall_q : stall_q + 1'b1);
    st_d = !cap && stall_d == TO;
    if (cap) begin
      shadow_d[slot*7 +: 7] = ~segments;
      seen_d = seen_q | (4'b1 << slot);
      as_d = slot;
      if (seen_d == 4'hf) begin
        frame_d = shadow_d;
        fv_d = 1'b1;
        fc_d = fc_q + 8'd1;
        seen_d = '0;
      end
    end
  end
`ifdef SEG_DECODE_EN
  // glyphs for F down to 0, bit order {a,b,c,d,e,f,g}
  localparam logic [111:0] GLYPHS = {7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
                                     7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E};
  logic [15:0] hex_q, hex_d;
  logic [3:0] ok_q, ok_d;
  always_comb begin
    hex_d = hex_q;
    ok_d = ok_q;
    if (fv_d) begin
      hex_d = '0;
      ok_d = '0;
      for (int j = 0; j < 4; j++)
        for (int i = 0; i < 16; i++)
          if (frame_d[j*7 +: 7] == GLYPHS[i*7 +: 7]) begin
            hex_d[j*4 +: 4] = 4'(i);
            ok_d[j] = 1'b1;
          end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      hex_q <= '0;
      ok_q <= '0;
    end else begin
      hex_q <= hex_d;
      ok_q <= ok_d;
    end
  assign hex_digits = hex_q;
  assign hex_ok = ok_q;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      slot_q <= '0;
      seen_q <= '0;
      shadow_q <= '0;
      frame_q <= '0;
      fv_q <= 1'b0;
      fc_q <= '0;
      cs_q <= 1'b0;
      as_q <= '0;
      ov_q <= 1'b0;
      stall_q <= '0;
      st_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      slot_q <= slot_d;
      seen_q <= seen_d;
      shadow_q <= shadow_d;
      frame_q <= frame_d;
      fv_q <= fv_d;
      fc_q <= fc_d;
      cs_q <= cs_d;
      as_q <= as_d;
      ov_q <= ov_d;
      stall_q <= stall_d;
      st_q <= st_d;
    end
  assign frame = frame_q;
  assign frame_valid = fv_q;
  assign frame_count = fc_q;
  assign capture_strobe = cs_q;
  assign active_slot = as_q;
  assign overlap_err = ov_q;
  assign scan_stalled = st_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: table, directed and randomized checks of seg_scan_capture at settle 1 and 3
module tb_seg_scan_capture;
  localparam int TO = 16;
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] anodes = 4'hf;
  logic [6:0] segments = 7'h7f;
  logic [27:0] f1, f3;
  logic fv1, fv3, cs1, cs3, ov1, ov3, st1, st3;
  logic [7:0] fc1, fc3;
  logic [1:0] as1, as3;
`ifdef SEG_DECODE_EN
  logic [15:0] hx1, hx3;
  logic [3:0] hok1, hok3;
`endif
  seg_scan_capture #(.SETTLE_CYCLES(1), .TIMEOUT_CYCLES(TO)) dut1 (
    .clk(clk), .reset(reset), .anodes(anodes), .segments(segments), .frame(f1),
    .frame_valid(fv1), .frame_count(fc1), .capture_strobe(cs1), .active_slot(as1),
    .overlap_err(ov1),
`ifdef SEG_DECODE_EN
    .hex_digits(hx1), .hex_ok(hok1),
`endif
    .scan_stalled(st1));
  seg_scan_capture #(.SETTLE_CYCLES(3), .TIMEOUT_CYCLES(TO)) dut3 (
    .clk(clk), .reset(reset), .anodes(anodes), .segments(segments), .frame(f3),
    .frame_valid(fv3), .frame_count(fc3), .capture_strobe(cs3), .active_slot(as3),
    .overlap_err(ov3),
`ifdef SEG_DECODE_EN
    .hex_digits(hx3), .hex_ok(hok3),
`endif
    .scan_stalled(st3));
  always #5 clk = ~clk;
  int n_pass = 0, n_total = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask
  // reference model: a capture happens when the same one-hot anode pattern has been
  // seen on exactly SETTLE consecutive edges
  int settle[2];
  int run[2], mstall[2];
  logic [3:0] last[2], seen[2];
  logic [6:0] sh[2][4];
  logic [27:0] mf[2];
  logic [7:0] mfc[2];
  logic [1:0] mas[2];
  logic mfv[2], mcs[2], mov[2], mst[2];
  task automatic m_reset();
    for (int m = 0; m < 2; m++) begin
      run[m] = 0; mstall[m] = 0; last[m] = 4'hf; seen[m] = 4'h0;
      for (int k = 0; k < 4; k++) sh[m][k] = 7'h0;
      mf[m] = '0; mfc[m] = '0; mas[m] = '0;
      mfv[m] = 1'b0; mcs[m] = 1'b0; mov[m] = 1'b0; mst[m] = 1'b0;
    end
  endtask
  task automatic m_edge(int m, logic [3:0] a, logic [6:0] s);
    int z, sl;
    logic cap;
    z = $countones(~a);
    sl = 0;
    for (int i = 0; i < 4; i++) if (!a[i]) sl = 3 - i;
    cap = 1'b0;
    mfv[m] = 1'b0;
    mcs[m] = 1'b0;
    if (z >= 2) begin
      mov[m] = 1'b1;
      run[m] = 0;
    end else if (z == 0) run[m] = 0;
    else begin
      run[m] = (run[m] > 0 && a == last[m]) ? run[m] + 1 : 1;
      last[m] = a;
      cap = run[m] == settle[m];
    end
    if (cap) begin
      sh[m][sl] = ~s;
      seen[m][sl] = 1'b1;
      mas[m] = 2'(sl);
      mcs[m] = 1'b1;
      mstall[m] = 0;
      mst[m] = 1'b0;
      if (seen[m] == 4'hf) begin
        mf[m] = {sh[m][3], sh[m][2], sh[m][1], sh[m][0]};
        mfv[m] = 1'b1;
        mfc[m] = mfc[m] + 8'd1;
        seen[m] = 4'h0;
      end
    end else begin
      if (mstall[m] < TO) mstall[m]++;
      mst[m] = mstall[m] == TO;
    end
  endtask
  task automatic cmp_all();
    chk("s1.frame", 32'(f1), 32'(mf[0]));
    chk("s1.frame_valid", 32'(fv1), 32'(mfv[0]));
    chk("s1.frame_count", 32'(fc1), 32'(mfc[0]));
    chk("s1.capture_strobe", 32'(cs1), 32'(mcs[0]));
    chk("s1.active_slot", 32'(as1), 32'(mas[0]));
    chk("s1.overlap_err", 32'(ov1), 32'(mov[0]));
    chk("s1.scan_stalled", 32'(st1), 32'(mst[0]));
    chk("s3.frame", 32'(f3), 32'(mf[1]));
    chk("s3.frame_valid", 32'(fv3), 32'(mfv[1]));
    chk("s3.frame_count", 32'(fc3), 32'(mfc[1]));
    chk("s3.capture_strobe", 32'(cs3), 32'(mcs[1]));
    chk("s3.active_slot", 32'(as3), 32'(mas[1]));
    chk("s3.overlap_err", 32'(ov3), 32'(mov[1]));
    chk("s3.scan_stalled", 32'(st3), 32'(mst[1]));
  endtask
  task automatic step(logic [3:0] a, logic [6:0] s);
    anodes = a;
    segments = s;
    @(posedge clk);
    m_edge(0, a, s);
    m_edge(1, a, s);
    #1;
    cmp_all();
  endtask
  task automatic do_reset();
    anodes = 4'hf;
    reset = 1'b1;
    #1;
    m_reset();
    chk("rst.s1.outs", {f1, fv1, cs1, ov1, st1}, 32'h0);
    chk("rst.s1.count_slot", {fc1, as1}, 32'h0);
    chk("rst.s3.outs", {f3, fv3, cs3, ov3, st3}, 32'h0);
    chk("rst.s3.count_slot", {fc3, as3}, 32'h0);
`ifdef SEG_DECODE_EN
    chk("rst.hex", {hx1, hok1}, 32'h0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  typedef struct {
    logic [3:0] a;
    logic [6:0] s;
    logic cs;
    logic [1:0] sl;
    logic fv;
  } vec_t;
  vec_t tbl[12];
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] a;
    int k, x, hold;
    settle[0] = 1;
    settle[1] = 3;
    tbl[0]  = '{4'b1111, 7'h7f, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'b0111, 7'h4f, 1'b1, 2'd0, 1'b0};
    tbl[2]  = '{4'b1111, 7'h7f, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{4'b1111, 7'h7f, 1'b0, 2'd0, 1'b0};
    tbl[4]  = '{4'b1011, 7'h12, 1'b1, 2'd1, 1'b0};
    tbl[5]  = '{4'b1111, 7'h7f, 1'b0, 2'd1, 1'b0};
    tbl[6]  = '{4'b1111, 7'h7f, 1'b0, 2'd1, 1'b0};
    tbl[7]  = '{4'b1101, 7'h06, 1'b1, 2'd2, 1'b0};
    tbl[8]  = '{4'b1111, 7'h7f, 1'b0, 2'd2, 1'b0};
    tbl[9]  = '{4'b1111, 7'h7f, 1'b0, 2'd2, 1'b0};
    tbl[10] = '{4'b1110, 7'h4c, 1'b1, 2'd3, 1'b1};
    tbl[11] = '{4'b1111, 7'h7f, 1'b0, 2'd3, 1'b0};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].a, tbl[i].s);
      chk("tbl.capture_strobe", 32'(cs1), 32'(tbl[i].cs));
      chk("tbl.active_slot", 32'(as1), 32'(tbl[i].sl));
      chk("tbl.frame_valid", 32'(fv1), 32'(tbl[i].fv));
    end
    chk("tbl.frame", 32'(f1), 32'({7'h33, 7'h79, 7'h6d, 7'h30}));
    chk("tbl.frame_count", 32'(fc1), 32'd1);
    step(4'b1011, 7'h11);
    step(4'b1011, 7'h11);
    chk("settle3.short_run", 32'(cs3), 32'd0);
    step(4'b1111, 7'h7f);
    chk("settle3.blank", 32'(cs3), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(4'b1011, 7'h22);
      chk("settle3.long_run", 32'(cs3), 32'(i == 2));
    end
    chk("settle3.slot", 32'(as3), 32'd1);
    do_reset();
    step(4'b0111, 7'h01);
    step(4'b1011, 7'h02);
    step(4'b0011, 7'h03);
    chk("ovl.flag", 32'(ov1), 32'd1);
    chk("ovl.no_capture", 32'(cs1), 32'd0);
    step(4'b1101, 7'h04);
    step(4'b1110, 7'h05);
    chk("ovl.frame_valid", 32'(fv1), 32'd1);
    step(4'b1111, 7'h7f);
    chk("ovl.sticky", 32'(ov1), 32'd1);
    do_reset();
    for (int i = 0; i < 15; i++) step(4'b1111, 7'h7f);
    chk("stall.before", 32'(st1), 32'd0);
    step(4'b1111, 7'h7f);
    chk("stall.rise", 32'(st1), 32'd1);
    step(4'b0111, 7'h40);
    chk("stall.clear", 32'(st1), 32'd0);
    chk("stall.s3_no_capture", 32'(st3), 32'd1);
    do_reset();
    for (int i = 0; i < 15; i++) step(4'b1111, 7'h7f);
    step(4'b0111, 7'h40);
    chk("stall.capture_wins", 32'(st1), 32'd0);
    do_reset();
    step(4'b0111, 7'h11);
    step(4'b1011, 7'h22);
    chk("midrst.slot_before", 32'(as1), 32'd1);
    do_reset();
    step(4'b1101, 7'h33);
    chk("midrst.no_frame_a", 32'(fv1), 32'd0);
    step(4'b1110, 7'h44);
    chk("midrst.no_frame_b", 32'(fv1), 32'd0);
    chk("midrst.count", 32'(fc1), 32'd0);
    do_reset();
    for (int f = 0; f < 256; f++) begin
      step(4'b0111, 7'($urandom));
      step(4'b1011, 7'($urandom));
      step(4'b1101, 7'($urandom));
      step(4'b1110, 7'($urandom));
      if (f == 254) chk("wrap.255", 32'(fc1), 32'd255);
    end
    chk("wrap.zero", 32'(fc1), 32'd0);
`ifdef SEG_DECODE_EN
    do_reset();
    step(4'b0111, 7'h00);
    step(4'b1011, 7'h08);
    step(4'b1101, 7'h38);
    chk("hex.before", 32'(hx1), 32'h0);
    step(4'b1110, 7'h7f);
    chk("hex.digits", 32'(hx1), 32'h0fa8);
    chk("hex.ok", 32'(hok1), 32'h7);
    chk("hex.s3_idle", {hx3, hok3}, 32'h0);
`endif
    do_reset();
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      k = int'($urandom_range(0, 19));
      x = int'($urandom_range(0, 3));
      if (k < 4) a = 4'hf;
      else if (k < 19) a = ~(4'b0001 << x);
      else a = ~((4'b0001 << x) | (4'b0001 << ((x + 1 + int'($urandom_range(0, 2))) % 4)));
      hold = int'($urandom_range(1, 5));
      for (int h = 0; h < hold; h++) step(a, 7'($urandom));
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
